// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared types for the RV32I front end (fetch state, fetch entry)
// Revision : 1.0
// ============================================================================
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : synchronous FIFO of fetched {pc, instr} entries with flush
// Revision    : 1.0
// ============================================================================
module fetch_queue
   import core_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  fetch_entry_t                 wdata_i,
   input  logic                         pop_i,
   input  logic                         clear_i,
   output fetch_entry_t                 rdata_o,
   output logic [$clog2(QDEPTH+1)-1:0]  count_o,
   output logic                         empty_o,
   output logic                         full_o
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);

   fetch_entry_t   mem_q [QDEPTH];
   logic [PW-1:0]  rd_ptr_q;
   logic [PW-1:0]  wr_ptr_q;
   logic [CW-1:0]  count_q;

   // Explicit wrap so non power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(QDEPTH));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : RV32I fetch stage - PC, credit-based issue, redirect draining
// Revision   : 1.0
// ============================================================================
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              QDEPTH   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [XLEN-1:0]  imem_rsp_data,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_instr,
   output logic [XLEN-1:0]  out_pc
);

   localparam int IW = $clog2(QDEPTH + 1);
   localparam int OW = IW + 1;

   fetch_state_t     state_q;
   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  rsp_pc_q;
   logic [IW-1:0]    inflight_q;
   logic [IW-1:0]    inflight_d;
   logic [IW-1:0]    drop_cnt_q;
   logic [IW-1:0]    stale;
   logic [XLEN-1:0]  redir_pc;
   logic [IW-1:0]    q_count;
   logic             q_empty;
   logic             q_full;
   fetch_entry_t     q_head;
   fetch_entry_t     q_wdata;
   logic             pop;
   logic             push;
   logic             flush;
   logic             req_fire;
   logic [OW-1:0]    occupancy;

   assign out_valid      = !q_empty && !redirect_valid;
   assign pop            = out_valid && out_ready;
   // Credits: buffered plus outstanding never exceed the queue depth.
   assign occupancy      = OW'(inflight_q) + OW'(q_count) - OW'(pop);
   assign imem_req_valid = (state_q == RUN) && !redirect_valid && (occupancy < OW'(QDEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign flush    = redirect_valid && (state_q != BOOT);
   assign push     = (state_q == RUN) && imem_rsp_valid && !redirect_valid;
   assign redir_pc = redirect_pc & ~32'h3;
   // While draining inflight already includes every stale response still owed.
   assign stale      = inflight_q - IW'(imem_rsp_valid);
   assign inflight_d = inflight_q + IW'(req_fire) - IW'(imem_rsp_valid);
   assign q_wdata    = '{pc: rsp_pc_q, instr: imem_rsp_data};
   assign out_instr  = q_head.instr;
   assign out_pc     = q_head.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         unique case (state_q)
            BOOT: state_q <= RUN;
            RUN, DRAIN: begin
               if (redirect_valid) begin
                  pc_q       <= redir_pc;
                  rsp_pc_q   <= redir_pc;
                  drop_cnt_q <= stale;
                  state_q    <= (stale != '0) ? DRAIN : RUN;
               end else if (state_q == RUN) begin
                  if (req_fire)       pc_q     <= pc_q + 32'd4;
                  if (imem_rsp_valid) rsp_pc_q <= rsp_pc_q + 32'd4;
               end else if (imem_rsp_valid) begin
                  drop_cnt_q <= drop_cnt_q - 1'b1;
                  if (drop_cnt_q == IW'(1)) state_q <= RUN;
               end
            end
            default: state_q <= BOOT;
         endcase
      end
   end

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (q_wdata),
      .pop_i   (pop),
      .clear_i (flush),
      .rdata_o (q_head),
      .count_o (q_count),
      .empty_o (q_empty),
      .full_o  (q_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (!q_full || pop));
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (inflight_q != '0));

endmodule
`default_nettype wire
